// File: rtl/m1m2_seq.sv
// Nonce-sweep sequencer driving the m1/m2 double-SHA256 control strobes.
// Optional hash counter enabled by defining M1M2_SEQ_HASH_COUNT_EN.
module m1m2_seq #(
    parameter int unsigned ROUNDS      = 64,
    parameter int unsigned WT_SW_ROUND = 16,
    parameter int unsigned CHECK_LAT   = 2
) (
    input  logic        clk_h,
    input  logic        rst_h,
    input  logic        start,
    input  logic        host_break,
    input  logic [31:0] nonce_start,
    input  logic [31:0] nonce_end,
    input  logic        m2_ticket2moon,
    output logic [31:0] m1_next_nonce,
    output logic        m1_wr_nonce,
    output logic        m1_abc_load,
    output logic        m1_abc_en,
    output logic        m1_wt_reg_en,
    output logic        m1_wt_sw,
    output logic [5:0]  m1_k_rom_address,
    output logic        m1_k_rom_clkh_en,
    output logic [3:0]  m2_header_ram_addr_a,
    output logic [3:0]  m2_header_ram_addr_b,
    output logic        m2_header_ram_wren,
    output logic        m2_abc_load,
    output logic        m2_abc_en,
    output logic        m2_wt_reg_en,
    output logic        m2_wt_sw,
    output logic [5:0]  m2_k_rom_address,
    output logic        m2_k_rom_clkh_en,
    output logic        m2_target_en_t0,
    output logic        catch_bits,
    output logic        busy,
    output logic        done,
    output logic        found,
    output logic [31:0] found_nonce,
    output logic [31:0] hash_count
);

    typedef enum logic [3:0] {
        S_IDLE, S_LOAD, S_M1_INIT, S_M1_RUN, S_M2_WB,
        S_M2_INIT, S_M2_RUN, S_CHECK, S_DONE
    } state_t;

    localparam logic [5:0] LAST_R    = 6'(ROUNDS - 1);
    localparam logic [6:0] WT_SW     = 7'(WT_SW_ROUND);
    localparam logic [5:0] CHK_LAST  = 6'(CHECK_LAT);

    state_t      state;
    logic [5:0]  cnt;
    logic [5:0]  nr;
    logic [31:0] cur;
    logic [31:0] end_q;
    logic        check_sample;

    assign nr            = cnt + 6'd1;
    assign m1_next_nonce = cur;
    assign check_sample  = (state == S_CHECK) && (cnt == CHK_LAST);

    // Outputs are registered from the state being entered, so each strobe
    // is visible in the same cycle the FSM occupies that state.
    always_ff @(posedge clk_h) begin
        m1_wr_nonce          <= 1'b0;
        m1_abc_load          <= 1'b0;
        m1_abc_en            <= 1'b0;
        m1_wt_reg_en         <= 1'b0;
        m1_wt_sw             <= 1'b0;
        m1_k_rom_address     <= '0;
        m1_k_rom_clkh_en     <= 1'b0;
        m2_header_ram_addr_a <= '0;
        m2_header_ram_addr_b <= '0;
        m2_header_ram_wren   <= 1'b0;
        m2_abc_load          <= 1'b0;
        m2_abc_en            <= 1'b0;
        m2_wt_reg_en         <= 1'b0;
        m2_wt_sw             <= 1'b0;
        m2_k_rom_address     <= '0;
        m2_k_rom_clkh_en     <= 1'b0;
        m2_target_en_t0      <= 1'b0;
        catch_bits           <= 1'b0;
        done                 <= 1'b0;
        if (rst_h) begin
            state       <= S_IDLE;
            cnt         <= '0;
            cur         <= '0;
            end_q       <= '0;
            busy        <= 1'b0;
            found       <= 1'b0;
            found_nonce <= '0;
        end else if (host_break) begin
            state <= S_IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    state       <= S_LOAD;
                    end_q       <= nonce_end;
                    cur         <= nonce_start;
                    found       <= 1'b0;
                    found_nonce <= '0;
                    busy        <= 1'b1;
                    m1_wr_nonce <= 1'b1;
                end
                S_LOAD: begin
                    state            <= S_M1_INIT;
                    m1_abc_load      <= 1'b1;
                    m1_k_rom_clkh_en <= 1'b1;
                end
                S_M1_INIT: begin
                    state            <= S_M1_RUN;
                    cnt              <= '0;
                    m1_abc_en        <= 1'b1;
                    m1_wt_reg_en     <= 1'b1;
                    m1_k_rom_clkh_en <= 1'b1;
                    m1_wt_sw         <= (WT_SW == 7'd0);
                end
                S_M1_RUN: if (cnt == LAST_R) begin
                    state                <= S_M2_WB;
                    cnt                  <= '0;
                    m2_header_ram_wren   <= 1'b1;
                    m2_header_ram_addr_b <= 4'd4;
                end else begin
                    cnt              <= nr;
                    m1_abc_en        <= 1'b1;
                    m1_wt_reg_en     <= 1'b1;
                    m1_k_rom_clkh_en <= 1'b1;
                    m1_k_rom_address <= nr;
                    m1_wt_sw         <= ({1'b0, nr} >= WT_SW);
                end
                S_M2_WB: if (cnt == 6'd3) begin
                    state            <= S_M2_INIT;
                    m2_abc_load      <= 1'b1;
                    m2_k_rom_clkh_en <= 1'b1;
                end else begin
                    cnt                  <= nr;
                    m2_header_ram_wren   <= 1'b1;
                    m2_header_ram_addr_a <= nr[3:0];
                    m2_header_ram_addr_b <= nr[3:0] + 4'd4;
                end
                S_M2_INIT: begin
                    state            <= S_M2_RUN;
                    cnt              <= '0;
                    m2_abc_en        <= 1'b1;
                    m2_wt_reg_en     <= 1'b1;
                    m2_k_rom_clkh_en <= 1'b1;
                    m2_wt_sw         <= (WT_SW == 7'd0);
                end
                S_M2_RUN: if (cnt == LAST_R) begin
                    state           <= S_CHECK;
                    cnt             <= '0;
                    m2_target_en_t0 <= 1'b1;
                    catch_bits      <= 1'b1;
                end else begin
                    cnt              <= nr;
                    m2_abc_en        <= 1'b1;
                    m2_wt_reg_en     <= 1'b1;
                    m2_k_rom_clkh_en <= 1'b1;
                    m2_k_rom_address <= nr;
                    m2_wt_sw         <= ({1'b0, nr} >= WT_SW);
                end
                S_CHECK: if (cnt == CHK_LAST) begin
                    cnt <= '0;
                    if (m2_ticket2moon) begin
                        state       <= S_DONE;
                        found       <= 1'b1;
                        found_nonce <= cur;
                        done        <= 1'b1;
                    end else if (cur == end_q) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                    end else begin
                        state       <= S_LOAD;
                        cur         <= cur + 32'd1;
                        m1_wr_nonce <= 1'b1;
                    end
                end else begin
                    cnt        <= nr;
                    catch_bits <= 1'b1;
                end
                S_DONE: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef M1M2_SEQ_HASH_COUNT_EN
    always_ff @(posedge clk_h) begin
        if (rst_h) begin
            hash_count <= '0;
        end else if (!host_break) begin
            if (state == S_IDLE && start) hash_count <= '0;
            else if (check_sample)        hash_count <= hash_count + 32'd1;
        end
    end
`else
    assign hash_count = '0;
`endif

endmodule

// File: tb/tb_m1m2_seq.sv
// Directed self-checking bench for m1m2_seq (default parameters).
module tb_m1m2_seq;

    logic        clk_h = 1'b0;
    logic        rst_h, start, host_break, m2_ticket2moon;
    logic [31:0] nonce_start, nonce_end;
    logic [31:0] m1_next_nonce, found_nonce, hash_count;
    logic        m1_wr_nonce, m1_abc_load, m1_abc_en, m1_wt_reg_en, m1_wt_sw, m1_k_rom_clkh_en;
    logic [5:0]  m1_k_rom_address, m2_k_rom_address;
    logic [3:0]  m2_header_ram_addr_a, m2_header_ram_addr_b;
    logic        m2_header_ram_wren, m2_abc_load, m2_abc_en, m2_wt_reg_en, m2_wt_sw, m2_k_rom_clkh_en;
    logic        m2_target_en_t0, catch_bits, busy, done, found;

    int vectors = 0;
    int miscompares = 0;

`ifdef M1M2_SEQ_HASH_COUNT_EN
    localparam bit HC = 1'b1;
`else
    localparam bit HC = 1'b0;
`endif

    logic        hit_arm;
    logic [31:0] hit_nonce;
    logic [31:0] nonce_log [8];
    logic        strobes_any, any_out;

    m1m2_seq #(.ROUNDS(64), .WT_SW_ROUND(16), .CHECK_LAT(2)) dut (
        .clk_h(clk_h), .rst_h(rst_h), .start(start), .host_break(host_break),
        .nonce_start(nonce_start), .nonce_end(nonce_end), .m2_ticket2moon(m2_ticket2moon),
        .m1_next_nonce(m1_next_nonce), .m1_wr_nonce(m1_wr_nonce), .m1_abc_load(m1_abc_load),
        .m1_abc_en(m1_abc_en), .m1_wt_reg_en(m1_wt_reg_en), .m1_wt_sw(m1_wt_sw),
        .m1_k_rom_address(m1_k_rom_address), .m1_k_rom_clkh_en(m1_k_rom_clkh_en),
        .m2_header_ram_addr_a(m2_header_ram_addr_a), .m2_header_ram_addr_b(m2_header_ram_addr_b),
        .m2_header_ram_wren(m2_header_ram_wren), .m2_abc_load(m2_abc_load), .m2_abc_en(m2_abc_en),
        .m2_wt_reg_en(m2_wt_reg_en), .m2_wt_sw(m2_wt_sw), .m2_k_rom_address(m2_k_rom_address),
        .m2_k_rom_clkh_en(m2_k_rom_clkh_en), .m2_target_en_t0(m2_target_en_t0),
        .catch_bits(catch_bits), .busy(busy), .done(done), .found(found),
        .found_nonce(found_nonce), .hash_count(hash_count)
    );

    always #5 clk_h = ~clk_h;

    assign strobes_any = |{m1_wr_nonce, m1_abc_load, m1_abc_en, m1_wt_reg_en, m1_wt_sw,
                           m1_k_rom_address, m1_k_rom_clkh_en, m2_header_ram_addr_a,
                           m2_header_ram_addr_b, m2_header_ram_wren, m2_abc_load, m2_abc_en,
                           m2_wt_reg_en, m2_wt_sw, m2_k_rom_address, m2_k_rom_clkh_en,
                           m2_target_en_t0, catch_bits, busy, done};
    assign any_out = strobes_any | (|{m1_next_nonce, found, found_nonce, hash_count});

    // Ticket responder: raises the hit flag only while the armed nonce is in CHECK.
    always @(negedge clk_h)
        m2_ticket2moon = hit_arm && catch_bits && (m1_next_nonce == hit_nonce);

    task automatic step;
        @(posedge clk_h);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic run_sweep(input logic [31:0] s, input logic [31:0] e, input int limit,
                             output int done_cyc, output int nn);
        nonce_start = s;
        nonce_end   = e;
        start = 1'b1;
        step();
        start = 1'b0;
        done_cyc = -1;
        nn = 0;
        for (int c = 1; c <= limit; c++) begin
            if (m1_wr_nonce) begin
                if (nn < 8) nonce_log[nn] = m1_next_nonce;
                nn++;
            end
            if (done) begin
                done_cyc = c;
                break;
            end
            step();
        end
    endtask

    initial begin
        int dc, nn;
        logic seen;
        rst_h = 1'b1; start = 1'b0; host_break = 1'b0;
        nonce_start = '0; nonce_end = '0; hit_arm = 1'b0; hit_nonce = '0;
        step(); step();
        chk("reset_outputs", 32'(any_out), 32'd0);
        rst_h = 1'b0;
        step();

        // Single nonce 0x10 with cycle-accurate strobe checks.
        nonce_start = 32'h10; nonce_end = 32'h10;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 1; c <= 139; c++) begin
            if (c == 1) begin
                chk("t1_wr_nonce", 32'(m1_wr_nonce), 32'd1);
                chk("t1_nonce", m1_next_nonce, 32'h10);
                chk("t1_busy", 32'(busy), 32'd1);
            end
            if (c == 2) begin
                chk("t1_m1_abc_load", 32'(m1_abc_load), 32'd1);
                chk("t1_m1_init_addr", 32'(m1_k_rom_address), 32'd0);
            end
            if (c >= 3 && c <= 66) begin
                chk("t1_m1_addr", 32'(m1_k_rom_address), 32'(c - 3));
                chk("t1_m1_wt_sw", 32'(m1_wt_sw), ((c - 3) >= 16) ? 32'd1 : 32'd0);
            end
            if (c == 67) chk("t1_wt_sw_fall", 32'(m1_wt_sw), 32'd0);
            if (c >= 67 && c <= 70) begin
                chk("t1_wb_wren", 32'(m2_header_ram_wren), 32'd1);
                chk("t1_wb_addr", {24'd0, m2_header_ram_addr_a, m2_header_ram_addr_b},
                    {24'd0, 4'(c - 67), 4'(c - 63)});
            end
            if (c == 136) chk("t1_target_en", 32'(m2_target_en_t0), 32'd1);
            if (c == 138) begin
                chk("t1_catch_bits", 32'(catch_bits), 32'd1);
                chk("t1_target_en_low", 32'(m2_target_en_t0), 32'd0);
                chk("t1_no_early_done", 32'(done), 32'd0);
            end
            if (c == 139) begin
                chk("t1_done", 32'(done), 32'd1);
                chk("t1_found", 32'(found), 32'd0);
                chk("t1_hash_count", hash_count, HC ? 32'd1 : 32'd0);
            end
            if (c < 139) step();
        end
        step();
        chk("t1_idle_busy", 32'(busy), 32'd0);
        chk("t1_done_pulse", 32'(done), 32'd0);

        // Hit on the third nonce of 0x100..0x104.
        hit_arm = 1'b1; hit_nonce = 32'h102;
        run_sweep(32'h100, 32'h104, 1000, dc, nn);
        chk("t2_done_cyc", 32'(dc), 32'd415);
        chk("t2_nonces", 32'(nn), 32'd3);
        chk("t2_nonce2", nonce_log[2], 32'h102);
        chk("t2_found", 32'(found), 32'd1);
        chk("t2_found_nonce", found_nonce, 32'h102);
        chk("t2_hash_count", hash_count, HC ? 32'd3 : 32'd0);
        hit_arm = 1'b0;
        step();
        chk("t2_found_hold", 32'(found), 32'd1);

        // Wrapping range, no hit.
        run_sweep(32'hFFFF_FFFE, 32'h0000_0001, 1000, dc, nn);
        chk("t3_done_cyc", 32'(dc), 32'd553);
        chk("t3_nonces", 32'(nn), 32'd4);
        chk("t3_nonce0", nonce_log[0], 32'hFFFF_FFFE);
        chk("t3_nonce1", nonce_log[1], 32'hFFFF_FFFF);
        chk("t3_nonce2", nonce_log[2], 32'h0000_0000);
        chk("t3_nonce3", nonce_log[3], 32'h0000_0001);
        chk("t3_found", 32'(found), 32'd0);
        step();

        // host_break during M2_RUN, then start colliding with host_break.
        nonce_start = 32'h0; nonce_end = 32'h5;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (79) step();
        chk("t4_in_m2_run", 32'(m2_abc_en), 32'd1);
        chk("t4_m2_addr", 32'(m2_k_rom_address), 32'd8);
        host_break = 1'b1;
        step();
        host_break = 1'b0;
        chk("t4_break_strobes", 32'(strobes_any), 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 150; i++) begin
            step();
            if (done || busy || m1_wr_nonce) seen = 1'b1;
        end
        chk("t4_stays_idle", 32'(seen), 32'd0);
        start = 1'b1; host_break = 1'b1;
        step();
        start = 1'b0; host_break = 1'b0;
        chk("t4_start_blocked", 32'(busy), 32'd0);
        chk("t4_no_wr_nonce", 32'(m1_wr_nonce), 32'd0);

        // Reset during CHECK, then a normal run.
        nonce_start = 32'h20; nonce_end = 32'h20;
        start = 1'b1;
        step();
        start = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (catch_bits) begin
                seen = 1'b1;
                break;
            end
            step();
        end
        chk("t5_reached_check", 32'(seen), 32'd1);
        rst_h = 1'b1;
        step();
        rst_h = 1'b0;
        chk("t5_rst_outputs", 32'(any_out), 32'd0);
        step();
        run_sweep(32'h30, 32'h30, 300, dc, nn);
        chk("t5_done_cyc", 32'(dc), 32'd139);
        chk("t5_nonce", nonce_log[0], 32'h30);
        chk("t5_found", 32'(found), 32'd0);
        chk("t5_hash_count", hash_count, HC ? 32'd1 : 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/m1m2_seq.md
# m1m2_seq

Nonce-sweep sequencer that drives all per-hash control strobes of the double-SHA256 core pair (m1 first hash, m2 second hash plus target check). It sits directly upstream of the core, between the host command interface and m1/m2. Per nonce it:

- writes the nonce into m1 and runs m1's rounds;
- copies m1's digest into m2's header RAM and runs m2's rounds;
- strobes the target check and samples `m2_ticket2moon`.

It stops on a hit, at the end of the range, or on `host_break`.

## Interface
Parameters:
- `ROUNDS`, 64: rounds per hash; the round counter is 6 bits.
- `WT_SW_ROUND`, 16: first round at which `m*_wt_sw` is high (message schedule switches from header words to expanded words).
- `CHECK_LAT`, 2: cycles from the `m2_target_en_t0` pulse to a valid `m2_ticket2moon`; range 1–7.

Ports:
- `clk_h` in 1: single clock; all logic on the rising edge.
- `rst_h` in 1: synchronous reset, active-high.
- `start` in 1: one-cycle pulse; starts a sweep when idle.
- `host_break` in 1: synchronous abort.
- `nonce_start` in 32: first nonce; sampled on an accepted `start`.
- `nonce_end` in 32: last nonce, inclusive; sampled on an accepted `start`.
- `m2_ticket2moon` in 1: hit flag from the core.
- `m1_next_nonce` out 32: nonce presented to m1.
- `m1_wr_nonce` out 1: nonce write strobe.
- `m1_abc_load`, `m1_abc_en`, `m1_wt_reg_en`, `m1_wt_sw` out 1 each: m1 datapath controls.
- `m1_k_rom_address` out 6: m1 K-ROM address.
- `m1_k_rom_clkh_en` out 1: m1 K-ROM clock enable.
- `m2_header_ram_addr_a`, `m2_header_ram_addr_b` out 4 each: m2 header RAM write addresses.
- `m2_header_ram_wren` out 1: m2 header RAM write enable.
- `m2_abc_load`, `m2_abc_en`, `m2_wt_reg_en`, `m2_wt_sw` out 1 each: m2 datapath controls.
- `m2_k_rom_address` out 6: m2 K-ROM address.
- `m2_k_rom_clkh_en` out 1: m2 K-ROM clock enable.
- `m2_target_en_t0` out 1: target-check start pulse.
- `catch_bits` out 1: high while waiting for the ticket.
- `busy` out 1: a sweep is in progress.
- `done` out 1: one-cycle end-of-sweep pulse.
- `found` out 1: a hit occurred in the last sweep.
- `found_nonce` out 32: the winning nonce.
- `hash_count` out 32: nonces fully checked since `start`; see Configuration.

## Operation
- **IDLE**
  - `busy`=0.
  - `start` latches the range, sets `cur` = `nonce_start`, clears `found` and `found_nonce`, then goes to LOAD.
  - `start` while busy is ignored.
- **LOAD** (1 cycle)
  - `m1_wr_nonce`=1, `m1_next_nonce`=`cur`. `m1_next_nonce` holds `cur` in all other states.
- **M1_INIT** (1 cycle)
  - `m1_abc_load`=1, `m1_k_rom_clkh_en`=1, `m1_k_rom_address`=0.
- **M1_RUN** (`ROUNDS` cycles, counter r = 0..ROUNDS-1)
  - `m1_abc_en`=`m1_wt_reg_en`=`m1_k_rom_clkh_en`=1.
  - `m1_k_rom_address`=r.
  - `m1_wt_sw`=(r ≥ `WT_SW_ROUND`).
- **M2_WB** (4 cycles, k = 0..3)
  - `m2_header_ram_wren`=1, `addr_a`=k, `addr_b`=k+4.
- **M2_INIT** and **M2_RUN**
  - Identical to M1_INIT and M1_RUN, using the m2 signals.
- **CHECK** (1 + `CHECK_LAT` cycles)
  - First cycle: `m2_target_en_t0`=1.
  - `catch_bits`=1 for the whole state.
  - `m2_ticket2moon` is sampled in the last cycle:
    - hit: `found`=1, `found_nonce`=`cur`, go to DONE;
    - else if `cur`==`nonce_end`: go to DONE;
    - else `cur`=`cur`+1 (mod 2^32) and go to LOAD.
- **DONE** (1 cycle)
  - `done`=1, then IDLE.
  - `found` and `found_nonce` hold until the next accepted `start`.
- Strobes not listed for a state are 0. K-ROM addresses read 0 outside the RUN states.

Boundary rules:
- `nonce_end` < `nonce_start`: the sweep wraps through 0xFFFFFFFF to 0x00000000.
- `nonce_start`==`nonce_end`: exactly one nonce.
- `host_break` in any state: IDLE next cycle, no `done`, `found` unchanged. It beats `start` in the same cycle.
- A hit on the nonce equal to `nonce_end`: `found`=1.
- `rst_h` mid-sweep: next cycle every output is 0 and the state is IDLE.

## Timing
- Reset value of every output: 0.
- Per-nonce period: 2·ROUNDS + 8 + CHECK_LAT = 138 cycles with default parameters.
- `start` at cycle 0 gives `m1_wr_nonce` at cycle 1.
- First `m2_target_en_t0` at cycle 1 + 1 + 1 + 64 + 4 + 1 + 64 = 136.
- `done` for a single-nonce miss comes at cycle 139.
- All outputs are registered.

## Configuration
- `M1M2_SEQ_HASH_COUNT_EN` defined:
  - `hash_count` increments at each CHECK sample;
  - it clears on an accepted `start` and on reset;
  - it wraps at 2^32.
- Not defined: `hash_count` is tied to 0 and the counter logic is absent.

## Test plan
- Reset, then `start` with range 0x10..0x10 and ticket held 0: `m1_wr_nonce` at cycle 1 with nonce 0x10, `done` at cycle 139, `found`=0, `hash_count`=1.
- Range 0x100..0x104, ticket forced 1 only during the nonce 0x102 check: `done` with `found`=1 and `found_nonce`=0x102; `hash_count`=3.
- Range 0xFFFFFFFE..0x00000001, no hit: the nonce sequence is FE, FF, 00, 01; `done` at cycle 4·138+1; `found`=0.
- During M1_RUN, check `m1_k_rom_address` steps 0..63, and `m1_wt_sw` rises exactly at r=16 and falls on leaving M1_RUN. During M2_WB, check the address pairs (0,4), (1,5), (2,6), (3,7).
- `host_break` in M2_RUN: IDLE next cycle, all strobes 0, no `done`. Then a `start` in the same cycle as `host_break`: ignored.
- `rst_h` asserted during CHECK with `catch_bits`=1: every output is 0 on the next edge, and a later `start` runs normally.
